// File: rtl/rd_cmd_arbiter.sv
// rd_cmd_arbiter: round-robin share of the RAM read-command stream.
// One registered, source-tagged output slot with full throughput.
module rd_cmd_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 97,
   parameter int SRC_W   = 2
) (
   input  logic                      clk_100_clk,
   input  logic                      reset_reset_n,
   input  logic [NUM_REQ-1:0]        req_tvalid,
   input  logic [NUM_REQ*DATA_W-1:0] req_tdata,
   output logic [NUM_REQ-1:0]        req_tready,
   input  logic [NUM_REQ-1:0]        req_enable,
   output logic [DATA_W-1:0]         cmd_tdata,
   output logic                      cmd_tvalid,
   input  logic                      cmd_tready,
   output logic [SRC_W-1:0]          cmd_tsrc,
   output logic [31:0]               cmd_count
);

   localparam int CW = SRC_W + 1;

   logic                 slot_valid;
   logic [SRC_W-1:0]     ptr;
   logic [NUM_REQ-1:0]   elig;
   logic [2*NUM_REQ-1:0] elig_dbl;
   logic [NUM_REQ-1:0]   elig_rot;
   logic                 load_en;
   logic                 win_found;
   logic [CW-1:0]        win_raw;
   logic [SRC_W-1:0]     win_idx;
   logic [SRC_W-1:0]     ptr_nxt;
   logic [DATA_W-1:0]    win_data;
   logic                 hs;

   assign elig     = req_tvalid & req_enable;
   assign load_en  = !slot_valid | (slot_valid & cmd_tready);
   assign elig_dbl = {elig, elig};
   // bit k of elig_rot is requester (ptr+k) mod NUM_REQ
   assign elig_rot = NUM_REQ'(elig_dbl >> ptr);

   always_comb begin
      win_found = 1'b0;
      win_raw   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && elig_rot[k]) begin
            win_found = 1'b1;
            win_raw   = CW'(ptr) + CW'(k);
         end
      end
   end

   assign win_idx = (win_raw >= CW'(NUM_REQ))
                  ? SRC_W'(win_raw - CW'(NUM_REQ))
                  : win_raw[SRC_W-1:0];

   assign ptr_nxt = (win_idx == SRC_W'(NUM_REQ - 1))
                  ? '0
                  : win_idx + SRC_W'(1);

   assign hs = load_en & win_found;

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == SRC_W'(i)) begin
            win_data = req_tdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      req_tready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_tready[i] = reset_reset_n & hs
                       & (win_idx == SRC_W'(i));
      end
   end

   always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         slot_valid <= 1'b0;
         cmd_tdata  <= '0;
         cmd_tsrc   <= '0;
         ptr        <= '0;
      end else if (load_en) begin
         slot_valid <= win_found;
         if (win_found) begin
            cmd_tdata <= win_data;
            cmd_tsrc  <= win_idx;
            ptr       <= ptr_nxt;
         end
      end
   end

   always_ff @(posedge clk_100_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cmd_count <= '0;
      end else if (slot_valid & cmd_tready) begin
         cmd_count <= cmd_count + 32'd1;
      end
   end

   assign cmd_tvalid = slot_valid;

endmodule

// File: tb/tb_rd_cmd_arbiter.sv
// tb_rd_cmd_arbiter: scoreboard bench for the read-command arbiter.
// Reference round-robin model predicts grants; queue holds the slot.
module tb_rd_cmd_arbiter;

   localparam int N  = 4;
   localparam int DW = 97;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_tvalid;
   logic [N*DW-1:0] req_tdata;
   logic [N-1:0]    req_tready;
   logic [N-1:0]    req_enable;
   logic [DW-1:0]   cmd_tdata;
   logic            cmd_tvalid;
   logic            cmd_tready;
   logic [1:0]      cmd_tsrc;
   logic [31:0]     cmd_count;

   rd_cmd_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(2)) dut (
      .clk_100_clk   (clk),
      .reset_reset_n (rst_n),
      .req_tvalid    (req_tvalid),
      .req_tdata     (req_tdata),
      .req_tready    (req_tready),
      .req_enable    (req_enable),
      .cmd_tdata     (cmd_tdata),
      .cmd_tvalid    (cmd_tvalid),
      .cmd_tready    (cmd_tready),
      .cmd_tsrc      (cmd_tsrc),
      .cmd_count     (cmd_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // stimulus state
   logic [N-1:0]  act;
   int            lim  [N];
   int            seq  [N];
   logic [DW-1:0] base [N];
   logic [N-1:0]  seen_rdy;

   // model state
   logic [DW+1:0] sb [$];
   int            m_ptr;
   int            m_cnt;
   int            cyc;
   int            log_src [$];
   logic [DW-1:0] log_dat [$];
   int            log_cyc [$];

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         req_tvalid[i] = act[i] && (seq[i] < lim[i]);
         req_tdata[i*DW +: DW] = base[i] + DW'(seq[i]);
      end
   endtask

   task automatic step();
      logic [N-1:0] acc;
      @(negedge clk);
      acc = req_tvalid & req_tready;
      seen_rdy = seen_rdy | req_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i]) seq[i]++;
      drive_inputs();
   endtask

   task automatic clear_logs();
      log_src.delete();
      log_dat.delete();
      log_cyc.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      act = '0;
      for (int i = 0; i < N; i++) seq[i] = 0;
      drive_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_logs(input int n, input int budget);
      int b;
      b = 0;
      while (log_src.size() < n && b < budget) begin
         step();
         b++;
      end
      if (log_src.size() < n) chk("timeout_logs", log_src.size(), n);
   endtask

   task automatic wait_src(input logic [1:0] s, input int budget);
      int b;
      b = 0;
      while (!(cmd_tvalid && cmd_tsrc == s) && b < budget) begin
         step();
         b++;
      end
      chk("wait_src", {cmd_tvalid, cmd_tsrc}, {1'b1, s});
   endtask

   // reference model and scoreboard
   always @(negedge clk) begin
      logic [N-1:0] elig;
      logic [N-1:0] exp_rdy;
      logic         m_load;
      logic         found;
      int           w;
      int           idx;
      cyc++;
      if (!rst_n) begin
         sb.delete();
         m_ptr = 0;
         m_cnt = 0;
         chk("rst_rdy", req_tready, 0);
         chk("rst_vld", cmd_tvalid, 0);
         chk("rst_dat", cmd_tdata, 0);
         chk("rst_src", cmd_tsrc, 0);
         chk("rst_cnt", cmd_count, 0);
      end else begin
         elig   = req_tvalid & req_enable;
         m_load = (sb.size() == 0) || cmd_tready;
         found  = 1'b0;
         w      = 0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && elig[idx]) begin
               found = 1'b1;
               w = idx;
            end
         end
         exp_rdy = (m_load && found) ? N'(1 << w) : '0;
         chk("rdy", req_tready, exp_rdy);
         chk("vld", cmd_tvalid, sb.size() != 0);
         chk("cnt", cmd_count, 32'(m_cnt));
         if (sb.size() != 0) begin
            chk("tdata", cmd_tdata, sb[0][DW-1:0]);
            chk("tsrc", cmd_tsrc, sb[0][DW+1:DW]);
            if (cmd_tready) begin
               log_src.push_back(int'(sb[0][DW+1:DW]));
               log_dat.push_back(sb[0][DW-1:0]);
               log_cyc.push_back(cyc);
               void'(sb.pop_front());
               m_cnt++;
            end
         end
         if (m_load && found) begin
            sb.push_back({2'(w), req_tdata[w*DW +: DW]});
            m_ptr = (w + 1) % N;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      cyc = 0;
      m_ptr = 0;
      m_cnt = 0;
      seen_rdy = '0;
      rst_n = 1'b1;
      cmd_tready = 1'b1;
      req_enable = '1;
      act = '1;
      for (int i = 0; i < N; i++) begin
         lim[i] = 1000;
         seq[i] = 0;
         base[i] = DW'(i) << 8;
      end
      drive_inputs();
      #1 rst_n = 1'b0;

      // reset with all requesters valid
      repeat (3) step();
      chk("s1_rdy", req_tready, 0);
      chk("s1_vld", cmd_tvalid, 0);
      chk("s1_dat", cmd_tdata, 0);
      chk("s1_src", cmd_tsrc, 0);
      chk("s1_cnt", cmd_count, 0);
      act = '0;
      drive_inputs();
      rst_n = 1'b1;

      // single requester streaming
      base[2] = DW'(12'h0A5);
      lim[2] = 8;
      act = 4'b0100;
      clear_logs();
      drive_inputs();
      wait_logs(8, 30);
      chk("s2_cnt", cmd_count, 8);
      for (int k = 0; k < 8 && k < log_src.size(); k++) begin
         chk("s2_src", log_src[k], 2);
         chk("s2_dat", log_dat[k], DW'(12'h0A5 + k));
         if (k > 0) chk("s2_gap", log_cyc[k] - log_cyc[k-1], 1);
      end

      // all requesters, round robin
      do_reset();
      for (int i = 0; i < N; i++) begin
         lim[i] = 1000;
         base[i] = DW'(i) << 8;
      end
      act = '1;
      clear_logs();
      drive_inputs();
      wait_logs(8, 30);
      for (int k = 0; k < 8 && k < log_src.size(); k++) begin
         chk("s3_src", log_src[k], k % 4);
         if (k > 0) chk("s3_gap", log_cyc[k] - log_cyc[k-1], 1);
      end

      // backpressure while source 1 is presented
      wait_src(2'd1, 20);
      cmd_tready = 1'b0;
      clear_logs();
      repeat (5) begin
         step();
         chk("s4_src", cmd_tsrc, 1);
         chk("s4_dat", cmd_tdata, (sb.size() != 0) ? sb[0][DW-1:0] : '1);
         chk("s4_rdy", req_tready, 0);
         chk("s4_cnt", cmd_count, 32'(m_cnt));
      end
      cmd_tready = 1'b1;
      wait_logs(4, 20);
      for (int k = 0; k < 4 && k < log_src.size(); k++) begin
         chk("s4_seq", log_src[k], (k + 1) % 4);
      end

      // enable mask
      do_reset();
      req_enable = 4'b1010;
      act = '1;
      seen_rdy = '0;
      clear_logs();
      drive_inputs();
      wait_logs(4, 20);
      for (int k = 0; k < 4 && k < log_src.size(); k++) begin
         chk("s5_src", log_src[k], (k % 2 == 0) ? 1 : 3);
      end
      chk("s5_mask", seen_rdy & 4'b0101, 0);
      req_enable = 4'b0000;
      step();
      chk("s5_drain", cmd_tvalid, 0);
      step();
      chk("s5_idle", cmd_tvalid, 0);

      // asynchronous reset mid-stream
      do_reset();
      req_enable = '1;
      act = '1;
      drive_inputs();
      wait_src(2'd3, 20);
      cmd_tready = 1'b0;
      step();
      step();
      chk("s6_stall", {cmd_tvalid, cmd_tsrc}, 3'b111);
      #1 rst_n = 1'b0;
      #1;
      chk("s6_vld", cmd_tvalid, 0);
      chk("s6_cnt", cmd_count, 0);
      chk("s6_rdy", req_tready, 0);
      chk("s6_src", cmd_tsrc, 0);
      step();
      step();
      cmd_tready = 1'b1;
      clear_logs();
      rst_n = 1'b1;
      wait_logs(1, 10);
      if (log_src.size() > 0) chk("s6_first", log_src[0], 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rd_cmd_arbiter.md
# rd_cmd_arbiter

Round-robin arbiter that shares the RAM controller's single read-command stream among several fabric requesters. It sits between the requester masters and the `ram_controller_1_src_read_cmd` stream port of the Qsys top. It accepts at most one command per cycle from the eligible requesters and presents it through a one-entry registered output slot. Each forwarded command is tagged with its source index so that read data can be routed back to the originating requester.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..16.
- `DATA_W`, default 97: command width; matches the read-command `tdata` width.
- `SRC_W`, default 2: source-tag width; must equal ceil(log2(NUM_REQ)).

Ports:
- `clk_100_clk`  in  1  single clock for the whole block.
- `reset_reset_n`  in  1  reset; asynchronous assertion, active-low.
- `req_tvalid`  in  NUM_REQ  per-requester command valid.
- `req_tdata`  in  NUM_REQ*DATA_W  requester i's command on bits [i*DATA_W +: DATA_W].
- `req_tready`  out  NUM_REQ  per-requester accept.
- `req_enable`  in  NUM_REQ  eligibility mask; 0 = never granted.
- `cmd_tdata`  out  DATA_W  command to the RAM controller.
- `cmd_tvalid`  out  1  command valid.
- `cmd_tready`  in  1  RAM controller accept.
- `cmd_tsrc`  out  SRC_W  index of the requester that issued `cmd_tdata`.
- `cmd_count`  out  32  total commands accepted downstream; wraps.

## Operation
- Output slot: registers `slot_valid`/`cmd_tdata`/`cmd_tsrc`; `cmd_tvalid` = `slot_valid`.
- `load_en` = !`slot_valid` | (`cmd_tvalid` & `cmd_tready`). The slot refills in the same cycle it drains, giving full throughput.
- Eligible requester i: `req_tvalid[i]` & `req_enable[i]`.
- Winner selection: search order is ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1. The first eligible requester in that order wins.
- `req_tready[i]` = `load_en` & winner exists & winner==i. This is combinational, at most one bit is high, and it is forced to 0 while reset is asserted.
- On a handshake with winner w:
  - the slot loads `req_tdata[w]` and `cmd_tsrc` <= w;
  - ptr <= w+1, wrapping from NUM_REQ-1 to 0, including non-power-of-2 NUM_REQ.
- No eligible requester while `load_en`=1: `slot_valid` <= 0 and ptr is unchanged.
- Stall (`cmd_tvalid` & !`cmd_tready`):
  - `cmd_tdata`/`cmd_tsrc` are held stable;
  - all `req_tready` are 0;
  - ptr is frozen.
- `req_enable[i]` deasserted while requester i's command is already in the slot: that command is still delivered.
- `cmd_tvalid` never depends on `cmd_tready`. `req_tready` may depend on `req_tvalid`.
- `cmd_count` increments by 1 on each `cmd_tvalid` & `cmd_tready`. It wraps 0xFFFFFFFF -> 0.
- Reset (asynchronous, at any time): `cmd_tvalid`=0, `cmd_tdata`=0, `cmd_tsrc`=0, `cmd_count`=0, ptr=0. A pending slot command is discarded, not replayed.

## Timing
- Latency: requester handshake in cycle N -> `cmd_tvalid` with that data in cycle N+1.
- Sustained throughput: 1 command/cycle whenever `cmd_tready`=1 and any requester is eligible.
- Fairness: with all NUM_REQ requesters continuously eligible and no stall, each is granted exactly once every NUM_REQ grants.
- Max wait: an eligible requester is granted within NUM_REQ-1 grants to others.
- First grant after reset release is decided at the first rising edge with `reset_reset_n`=1. Search starts at requester 0.
- All outputs are 0 while `reset_reset_n`=0.

## Test plan
1. Reset: hold `reset_reset_n`=0 with `req_tvalid`=4'hF. Required: `req_tready`=0, `cmd_tvalid`=0, `cmd_tdata`=0, `cmd_tsrc`=0, `cmd_count`=0.
2. Single requester, streaming: requester 2 offers 8 back-to-back commands, `tdata`=0x0A5+k; `cmd_tready`=1. Required: `cmd_tvalid` from the cycle after the first accept, `cmd_tdata` 0x0A5..0x0AC on consecutive cycles, `cmd_tsrc`=2 throughout, `cmd_count`=8.
3. All requesters, round robin: all 4 continuously valid, `cmd_tready`=1. Required: `cmd_tsrc` sequence 0,1,2,3,0,1,2,3 with no bubbles.
4. Backpressure: same as scenario 3, but drop `cmd_tready` for 5 cycles while `cmd_tsrc`=1 is presented. Required: `cmd_tdata`/`cmd_tsrc` stable, `req_tready`=0, `cmd_count` unchanged. After release: sequence continues 1,2,3,0.
5. Enable mask: all valid, `req_enable`=4'b1010. Required: `cmd_tsrc` 1,3,1,3 and `req_tready[0]`, `req_tready[2]` never high. Then set `req_enable`=4'b0000. Required: the slot drains and `cmd_tvalid`=0 on the next cycle.
6. Reset mid-stream: slot full under stall with `cmd_tsrc`=3. Assert reset asynchronously. Required: `cmd_tvalid` drops with no clock edge, and `cmd_count`=0. After release with all valid, the first `cmd_tsrc`=0.
